// File: rtl/hub_pkg.sv
// Shared types and helpers for the nonce hub: the transmit FSM states and
// the derived core-id width.
package hub_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_t;

    // A single core still needs a one-bit id field.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hub_fifo.sv
// Synchronous FIFO with show-ahead read data and full, empty and level flags.
// A write is refused when full and a read when empty, whatever the other port does.
module hub_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    // Head entry is visible combinationally so a pop can load it on the same edge.
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/nonce_hub.sv
// Collects golden nonces from CORES hashing cores, queues them round-robin
// and hands them one at a time to the serial core over a send/busy handshake.
module nonce_hub
    import hub_pkg::*;
#(
    parameter int CORES        = 4,
    parameter int NONCE_WIDTH  = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 1024,
    localparam int ID_W = id_width(CORES),
    localparam int LW   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CORES-1:0]             got_ticket,
    input  logic [CORES*NONCE_WIDTH-1:0] core_nonce,
    output logic [NONCE_WIDTH-1:0]       tx_word,
    output logic [ID_W-1:0]              tx_core_id,
    output logic                         tx_send,
    input  logic                         tx_busy,
    output logic                         new_nonce,
    output logic [LW-1:0]                fifo_level,
    output logic [15:0]                  drop_count
);

    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

    logic [CORES-1:0]        tk_d_reg;
    logic [CORES-1:0]        rise;
    logic [CORES-1:0]        granted;
    logic [CORES-1:0]        cap_drop;
    logic [CORES-1:0]        pend_vec;
    logic [NONCE_WIDTH-1:0]  pend_nonce [CORES];
    logic [ID_W-1:0]         ptr_reg;
    logic [ID_W-1:0]         grant_idx;
    logic                    grant_found;
    logic                    wr_en;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ID_W+NONCE_WIDTH-1:0] fifo_rd_data;
    tx_state_t               state_reg;
    tx_state_t               state_next;
    logic                    pop;
    logic                    tx_timeout;
    logic [TW-1:0]           timer_reg;
    logic [NONCE_WIDTH-1:0]  tx_word_reg;
    logic [ID_W-1:0]         tx_core_id_reg;
    logic                    new_nonce_reg;
    logic [15:0]             drop_count_reg;
    logic [15:0]             drop_count_next;
    int                      drop_sum;

    genvar gi;
    generate
        for (gi = 0; gi < CORES; gi++) begin : g_core
            logic                   pending_reg;
            logic [NONCE_WIDTH-1:0] nonce_reg;

            assign rise[gi]       = got_ticket[gi] & ~tk_d_reg[gi];
            assign granted[gi]    = wr_en && (grant_idx == ID_W'(gi));
            assign cap_drop[gi]   = rise[gi] & pending_reg & ~granted[gi];
            assign pend_vec[gi]   = pending_reg;
            assign pend_nonce[gi] = nonce_reg;

            // A grant frees the slot on the same edge, so a simultaneous capture is not a drop.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pending_reg <= 1'b0;
                    nonce_reg   <= '0;
                end else if (rise[gi] && (!pending_reg || granted[gi])) begin
                    pending_reg <= 1'b1;
                    nonce_reg   <= core_nonce[gi*NONCE_WIDTH +: NONCE_WIDTH];
                end else if (granted[gi]) begin
                    pending_reg <= 1'b0;
                end
            end
        end
    endgenerate

    // Round-robin: first pending core at or after ptr_reg, wrapping.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < CORES; k++) begin
            if (!grant_found && pend_vec[(int'(ptr_reg) + k) % CORES]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(ptr_reg) + k) % CORES);
            end
        end
    end

    assign wr_en = grant_found & ~fifo_full;

    hub_fifo #(
        .WIDTH (ID_W + NONCE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data ({grant_idx, pend_nonce[grant_idx]}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        tx_timeout = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: state_next = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end else if (timer_reg == TW'(BUSY_TIMEOUT - 1)) begin
                    tx_timeout = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture drops and a send timeout can land on the same edge; add them all.
    always_comb begin
        drop_sum        = int'(drop_count_reg) + $countones(cap_drop) + int'(tx_timeout);
        drop_count_next = (drop_sum > 65535) ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tk_d_reg       <= '0;
            ptr_reg        <= '0;
            timer_reg      <= '0;
            tx_word_reg    <= '0;
            tx_core_id_reg <= '0;
            new_nonce_reg  <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            tk_d_reg       <= got_ticket;
            new_nonce_reg  <= wr_en;
            drop_count_reg <= drop_count_next;
            timer_reg      <= (state_reg == WAIT_HI) ? timer_reg + 1'b1 : '0;
            if (wr_en) begin
                ptr_reg <= (grant_idx == ID_W'(CORES - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (pop) begin
                tx_word_reg    <= fifo_rd_data[NONCE_WIDTH-1:0];
                tx_core_id_reg <= fifo_rd_data[ID_W+NONCE_WIDTH-1:NONCE_WIDTH];
            end
        end
    end

    assign tx_word    = tx_word_reg;
    assign tx_core_id = tx_core_id_reg;
    assign tx_send    = (state_reg == SEND);
    assign new_nonce  = new_nonce_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_nonce_hub.sv
// Directed bench for nonce_hub: a cycle table for simultaneous tickets plus
// hand-written sequences for single ticket, backpressure, timeout, reset and fairness.
module tb_nonce_hub;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   got_ticket;
    logic [127:0] core_nonce;
    logic [31:0]  tx_word;
    logic [1:0]   tx_core_id;
    logic         tx_send;
    logic         tx_busy;
    logic         new_nonce;
    logic [3:0]   fifo_level;
    logic [15:0]  drop_count;

    nonce_hub dut (
        .clk        (clk),
        .rst        (rst),
        .got_ticket (got_ticket),
        .core_nonce (core_nonce),
        .tx_word    (tx_word),
        .tx_core_id (tx_core_id),
        .tx_send    (tx_send),
        .tx_busy    (tx_busy),
        .new_nonce  (new_nonce),
        .fifo_level (fifo_level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  gt;
        logic        busy;
        logic [3:0]  lvl;
        logic        nn;
        logic        send;
        logic [31:0] word;
        logic [1:0]  id;
    } vec_t;

    vec_t vecs [24];
    int   errors;
    int   checks;

    function automatic vec_t mk(input logic [3:0] gt, input logic busy, input logic [3:0] lvl,
                                input logic nn, input logic send, input logic [31:0] word,
                                input logic [1:0] id);
        vec_t v;
        v.gt = gt; v.busy = busy; v.lvl = lvl; v.nn = nn;
        v.send = send; v.word = word; v.id = id;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        got_ticket = '0;
        core_nonce = '0;
        tx_busy    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_nonce(input int core, input logic [31:0] value);
        core_nonce[core*32 +: 32] = value;
    endtask

    // Waits for one send from IDLE, then acknowledges it with a one-cycle busy pulse.
    task automatic drain_one(output logic [31:0] w, output logic [1:0] id);
        int n;
        n = 0;
        tx_busy = 1'b0;
        tick();
        while (!tx_send && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!tx_send) begin
            errors++;
            $display("FAIL drain: no tx_send within 50 cycles");
        end
        w  = tx_word;
        id = tx_core_id;
        $display("tx word=%h core=%0d drops=%0d", w, id, drop_count);
        tick();
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
    endtask

    logic [31:0] w;
    logic [1:0]  id;
    int          send_cyc;
    int          sends;
    int          nns;
    int          n;
    logic [31:0] sw;
    logic [1:0]  sid;

    initial begin
        errors = 0;
        checks = 0;
        do_reset();

        // Reset state
        check("rst_word", tx_word, 0);
        check("rst_id", tx_core_id, 0);
        check("rst_send", tx_send, 0);
        check("rst_nn", new_nonce, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", drop_count, 0);

        // Simultaneous tickets on all cores, then four handshaked sends
        vecs[0]  = mk(4'hF & 4'h0, 1, 0, 0, 0, 32'h0,  0);
        vecs[1]  = mk(4'hF, 1, 0, 0, 0, 32'h0,  0);
        vecs[2]  = mk(4'hF, 1, 1, 1, 0, 32'h0,  0);
        vecs[3]  = mk(4'hF, 1, 2, 1, 0, 32'h0,  0);
        vecs[4]  = mk(4'h0, 1, 3, 1, 0, 32'h0,  0);
        vecs[5]  = mk(4'h0, 1, 4, 1, 0, 32'h0,  0);
        vecs[6]  = mk(4'h0, 1, 4, 0, 0, 32'h0,  0);
        vecs[7]  = mk(4'h0, 0, 3, 0, 1, 32'h10, 0);
        vecs[8]  = mk(4'h0, 0, 3, 0, 0, 32'h10, 0);
        vecs[9]  = mk(4'h0, 1, 3, 0, 0, 32'h10, 0);
        vecs[10] = mk(4'h0, 0, 3, 0, 0, 32'h10, 0);
        vecs[11] = mk(4'h0, 0, 2, 0, 1, 32'h11, 1);
        vecs[12] = mk(4'h0, 0, 2, 0, 0, 32'h11, 1);
        vecs[13] = mk(4'h0, 1, 2, 0, 0, 32'h11, 1);
        vecs[14] = mk(4'h0, 0, 2, 0, 0, 32'h11, 1);
        vecs[15] = mk(4'h0, 0, 1, 0, 1, 32'h12, 2);
        vecs[16] = mk(4'h0, 0, 1, 0, 0, 32'h12, 2);
        vecs[17] = mk(4'h0, 1, 1, 0, 0, 32'h12, 2);
        vecs[18] = mk(4'h0, 0, 1, 0, 0, 32'h12, 2);
        vecs[19] = mk(4'h0, 0, 0, 0, 1, 32'h13, 3);
        vecs[20] = mk(4'h0, 0, 0, 0, 0, 32'h13, 3);
        vecs[21] = mk(4'h0, 1, 0, 0, 0, 32'h13, 3);
        vecs[22] = mk(4'h0, 0, 0, 0, 0, 32'h13, 3);
        vecs[23] = mk(4'h0, 0, 0, 0, 0, 32'h13, 3);
        for (int i = 0; i < 4; i++) set_nonce(i, 32'h10 + i);
        for (int r = 0; r < 24; r++) begin
            got_ticket = vecs[r].gt;
            tx_busy    = vecs[r].busy;
            tick();
            $display("row %0d level=%0d nn=%0d send=%0d word=%h id=%0d",
                     r, fifo_level, new_nonce, tx_send, tx_word, tx_core_id);
            check($sformatf("row%0d_level", r), fifo_level, vecs[r].lvl);
            check($sformatf("row%0d_nn", r), new_nonce, vecs[r].nn);
            check($sformatf("row%0d_send", r), tx_send, vecs[r].send);
            check($sformatf("row%0d_word", r), tx_word, vecs[r].word);
            check($sformatf("row%0d_id", r), tx_core_id, vecs[r].id);
            check($sformatf("row%0d_drop", r), drop_count, 0);
        end

        // Single ticket held 5 cycles on core 2; busy pulses 3 cycles after the send
        send_cyc = -1; sends = 0; nns = 0; sw = '0; sid = '0;
        set_nonce(2, 32'hDEADBEEF);
        for (int c = 0; c < 30; c++) begin
            got_ticket = (c < 5) ? 4'b0100 : 4'b0000;
            tx_busy    = (send_cyc >= 0) && (c >= send_cyc + 3) && (c <= send_cyc + 5);
            tick();
            if (new_nonce) nns++;
            if (tx_send) begin
                sends++;
                if (send_cyc < 0) begin
                    send_cyc = c;
                    sw  = tx_word;
                    sid = tx_core_id;
                end
            end
        end
        $display("single ticket: sends=%0d at cycle %0d word=%h id=%0d", sends, send_cyc, sw, sid);
        check("single_sends", sends, 1);
        check("single_latency", send_cyc, 2);
        check("single_word", sw, 32'hDEADBEEF);
        check("single_id", sid, 2);
        check("single_nn", nns, 1);

        // Backpressure: three rounds of four tickets with busy held high
        do_reset();
        tx_busy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c % 4 == 0) begin
                got_ticket = 4'hF;
                for (int i = 0; i < 4; i++) set_nonce(i, ((c / 4 + 1) << 8) + i);
            end else begin
                got_ticket = 4'h0;
            end
            tick();
        end
        check("bp_level_full", fifo_level, 8);
        check("bp_drop_none", drop_count, 0);
        check("bp_nn_idle", new_nonce, 0);
        got_ticket = 4'b0010;
        set_nonce(1, 32'h401);
        tick();
        check("bp_drop_rerise", drop_count, 1);
        check("bp_level_hold", fifo_level, 8);
        got_ticket = 4'h0;
        tick();
        check("bp_drop_stable", drop_count, 1);
        for (int k = 0; k < 12; k++) begin
            drain_one(w, id);
            check($sformatf("bp_word%0d", k), w, ((k / 4 + 1) << 8) + (k % 4));
            check($sformatf("bp_id%0d", k), id, k % 4);
        end
        check("bp_level_empty", fifo_level, 0);

        // Timeout: busy never rises after the first send
        do_reset();
        set_nonce(0, 32'hA0);
        set_nonce(1, 32'hA1);
        got_ticket = 4'b0011;
        tick();
        got_ticket = 4'h0;
        n = 0;
        while (!tx_send && n < 20) begin
            tick();
            n++;
        end
        check("to_first_send", tx_send, 1);
        check("to_first_word", tx_word, 32'hA0);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1024) check("to_drop_before", drop_count, 0);
            if (n == 1025) check("to_drop_after", drop_count, 1);
        end while (!tx_send && n < 2000);
        $display("timeout: next send after %0d cycles word=%h id=%0d", n, tx_word, tx_core_id);
        check("to_gap", n, 1026);
        check("to_next_word", tx_word, 32'hA1);
        check("to_next_id", tx_core_id, 1);

        // Asynchronous reset in WAIT_LO with three entries still queued
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) set_nonce(i, 32'hB0 + i);
        got_ticket = 4'hF;
        tick();
        got_ticket = 4'h0;
        for (int k = 0; k < 4; k++) tick();
        check("ar_level4", fifo_level, 4);
        tx_busy = 1'b0;
        tick();
        check("ar_send", tx_send, 1);
        check("ar_word", tx_word, 32'hB0);
        tick();
        tx_busy = 1'b1;
        tick();
        check("ar_level3", fifo_level, 3);
        #2;
        rst = 1'b1;
        #1;
        check("ar_word0", tx_word, 0);
        check("ar_id0", tx_core_id, 0);
        check("ar_send0", tx_send, 0);
        check("ar_nn0", new_nonce, 0);
        check("ar_level0", fifo_level, 0);
        check("ar_drop0", drop_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_busy = 1'b0;
        sends = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (tx_send) sends++;
        end
        check("ar_no_send", sends, 0);
        check("ar_level_after", fifo_level, 0);

        // Fairness: core 0 re-tickets every 4 cycles, core 3 joins at cycle 4
        do_reset();
        tx_busy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            got_ticket = {(c == 4), 2'b00, (c % 4 == 0)};
            set_nonce(0, 32'hC0 + c);
            set_nonce(3, 32'hD3);
            tick();
        end
        got_ticket = 4'h0;
        check("fair_level", fifo_level, 4);
        check("fair_drop", drop_count, 0);
        drain_one(w, id);
        check("fair_w0", w, 32'hC0);
        check("fair_id0", id, 0);
        drain_one(w, id);
        check("fair_w1", w, 32'hD3);
        check("fair_id1", id, 3);
        drain_one(w, id);
        check("fair_w2", w, 32'hC4);
        check("fair_id2", id, 0);
        drain_one(w, id);
        check("fair_w3", w, 32'hC8);
        check("fair_id3", id, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nonce_hub.md
Name: nonce_hub

Overview:
- Parametrised successor to the single-slave ticket/hub path: collects golden nonces from CORES hashing cores, all on one clock.
- Detects each core's ticket edge, latches its nonce, and arbitrates round-robin into a FIFO.
- Drains the FIFO to the serial core with a send/busy handshake.
- Sits between the sha256_top instances and serial_core, replacing the hub_core plus ticket FSM pair.

Parameters:
- CORES, 4, number of hashing cores (1..16).
- NONCE_WIDTH, 32, width of each golden nonce.
- FIFO_DEPTH, 8, nonce FIFO entries (power of two, >=2).
- BUSY_TIMEOUT, 1024, cycles to wait for tx_busy to rise before abandoning a send.
- ID_W, $clog2(CORES) min 1, core-id width (derived, not overridden).

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  asynchronous, active-high reset.
- got_ticket  in  CORES  per-core ticket level; core i drives bit i and holds it >=1 cycle.
- core_nonce  in  CORES*NONCE_WIDTH  flattened nonces; core i occupies [i*NONCE_WIDTH +: NONCE_WIDTH].
- tx_word  out  NONCE_WIDTH  nonce presented to serial_core.
- tx_core_id  out  ID_W  source core of tx_word.
- tx_send  out  1  one-cycle send strobe.
- tx_busy  in  1  serial_core busy flag.
- new_nonce  out  1  one-cycle pulse per nonce accepted into the FIFO (LED fader trigger).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  out  16  nonces lost; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO empty; pending flags clear; arbiter pointer 0; FSM IDLE; ticket history registers 0.

Capture:
- rise[i] = got_ticket[i] & ~tk_d[i], where tk_d is got_ticket registered.
- On an edge with rise[i] and pending[i]=0: pending[i] is set and pend_nonce[i] is loaded with core_nonce slice i.
- If pending[i] is already 1: drop_count increments, and the old pending value is kept.
- A level held high yields exactly one capture. Re-capture requires a low cycle.

Arbiter:
- Each edge, when any pending bit is set and the FIFO is not full, grant the first pending core at or after ptr (wrapping).
- The granted core's nonce and id are written to the FIFO, its pending bit is cleared, and ptr becomes grant+1 mod CORES.
- new_nonce is registered high for one cycle on each write.
- FIFO full: nothing is written; pending bits hold (backpressure, no drop).
- Capture and grant on the same core in the same edge: the grant clears the old value and the capture sets it again with the new nonce. No drop.

FIFO:
- Write and read in the same cycle: level unchanged. Both are legal when full or empty only if the respective condition allows.
- A write is blocked when full, even if a read occurs in the same cycle (level is registered).
- Pointers wrap modulo FIFO_DEPTH.

TX FSM (IDLE, SEND, WAIT_HI, WAIT_LO):
- IDLE: FIFO non-empty and tx_busy=0 -> pop; load tx_word and tx_core_id; go to SEND.
- SEND: tx_send=1 for this cycle only -> WAIT_HI.
- WAIT_HI: tx_busy=1 -> WAIT_LO. If the timeout counter reaches BUSY_TIMEOUT-1 -> IDLE and increment drop_count.
- WAIT_LO: tx_busy=0 -> IDLE.
- tx_word and tx_core_id hold until the next pop.

Latency:
- Ticket rising at sample edge k: pending set at k, FIFO write at k+1, pop at k+2, tx_send high in the cycle after k+2.
- Minimum 3 edges from the ticket to tx_send.

Other rules:
- drop_count saturates; simultaneous drop sources in one cycle add their sum, saturating.
- Reset mid-send: FSM returns to IDLE; queued nonces are discarded.

Decomposition:
- Package hub_pkg holds the FSM state enum (IDLE, SEND, WAIT_HI, WAIT_LO) and a function computing the id width with minimum 1.
- One sub-module: hub_fifo, a parametrised width/depth synchronous FIFO with async reset, plus full, empty and level outputs.
- The round-robin arbiter stays inline.

Test Plan:
- Single ticket: core 2 raises got_ticket with nonce 32'hDEADBEEF for 5 cycles, tx_busy pulses high 3 cycles after send. Expect exactly one tx_send, tx_word DEADBEEF, tx_core_id 2, and one new_nonce pulse.
- Simultaneous tickets: all 4 cores raise in the same cycle with nonces 10, 11, 12, 13, ptr=0. Expect FIFO order 10, 11, 12, 13 over 4 consecutive cycles; fifo_level peaks at 4; then 4 sends.
- Backpressure: tx_busy held high, 12 tickets arrive spread over cores with FIFO_DEPTH=8. Expect fifo_level=8, pending bits hold, and drop_count increments only on re-rise of a pending core.
- Timeout: tx_busy never rises after a send. Expect return to IDLE after 1024 cycles, drop_count=1, and the next entry sent.
- Async reset: assert rst mid-WAIT_LO with 3 entries queued. Expect all outputs 0 immediately, fifo_level 0, and no tx_send after release.
- Fairness: core 0 re-tickets every 4 cycles while core 3 has a pending nonce. Expect core 3 granted within 1 grant of becoming pending.
